// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared FIFO pointer constants and Gray-code helpers
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

   localparam int DEFAULT_ASIZE = 4;
   // Widest pointer any FIFO built on this package may use (ASIZE up to 16).
   localparam int PTR_MAX_W     = 17;

   typedef logic [PTR_MAX_W-1:0] ptr_t;

   function automatic ptr_t bin2gray(input ptr_t b);
      return b ^ (b >> 1);
   endfunction

   function automatic ptr_t gray2bin(input ptr_t g);
      ptr_t b;
      b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
      for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/sync_r2w.sv
`default_nettype none
// ============================================================================
// Module      : sync_r2w
// Description : Two-flop synchronizer carrying the read pointer into wclk
// Revision    : 1.0 - initial release
// ============================================================================
module sync_r2w
   import fifo_pkg::*;
#(
   parameter int WIDTH = DEFAULT_ASIZE + 1
) (
   input  logic             wclk,
   input  logic             wrst,
   input  logic [WIDTH-1:0] rptr,
   output logic [WIDTH-1:0] wq2_rptr
);

   logic [WIDTH-1:0] wq1_rptr;

   always_ff @(posedge wclk) begin
      if (wrst) begin
         wq1_rptr <= '0;
         wq2_rptr <= '0;
      end else begin
         wq1_rptr <= rptr;
         wq2_rptr <= wq1_rptr;
      end
   end

endmodule : sync_r2w
`default_nettype wire

// File: rtl/wptr_full.sv
`default_nettype none
// ============================================================================
// Module      : wptr_full
// Description : Async-FIFO write pointer, full/overflow flags; optional
//               occupancy and almost-full logic under WPTR_ALMOST_FULL_EN
// Revision    : 1.0 - initial release
// ============================================================================
module wptr_full
   import fifo_pkg::*;
#(
   parameter int ASIZE     = DEFAULT_ASIZE,
   parameter int AF_THRESH = (1 << ASIZE) - 2
) (
   input  logic             wclk,
   input  logic             wrst,
   input  logic             w_en,
   input  logic [ASIZE:0]   rptr,
   output logic [ASIZE-1:0] waddr,
   output logic [ASIZE:0]   wptr,
   output logic             wfull,
   output logic             walmost_full,
   output logic [ASIZE:0]   wcount,
   output logic             woverflow
);

   localparam int PW = ASIZE + 1;

   if ((ASIZE < 2) || (ASIZE > 16) || (AF_THRESH < 0) || (AF_THRESH > (1 << ASIZE)))
   begin : g_bad_param
      $error("wptr_full: ASIZE or AF_THRESH out of range");
   end

   logic [ASIZE:0] wbin;
   logic [ASIZE:0] wbinnext;
   logic [ASIZE:0] wgraynext;
   logic [ASIZE:0] wq2_rptr;
   logic [ASIZE:0] full_match;

   sync_r2w #(.WIDTH(PW)) u_sync_r2w (
      .wclk     (wclk),
      .wrst     (wrst),
      .rptr     (rptr),
      .wq2_rptr (wq2_rptr)
   );

   assign wbinnext  = wbin + {{ASIZE{1'b0}}, (w_en & ~wfull)};
   assign wgraynext = PW'(bin2gray(PTR_MAX_W'(wbinnext)));
   // Full when the write pointer is exactly one lap ahead of the read pointer.
   assign full_match = {~wq2_rptr[ASIZE:ASIZE-1], wq2_rptr[ASIZE-2:0]};
   assign waddr      = wbin[ASIZE-1:0];

   always_ff @(posedge wclk) begin
      if (wrst) begin
         wbin      <= '0;
         wptr      <= '0;
         wfull     <= 1'b0;
         woverflow <= 1'b0;
      end else begin
         wbin      <= wbinnext;
         wptr      <= wgraynext;
         wfull     <= (wgraynext == full_match);
         woverflow <= woverflow | (w_en & wfull);
      end
   end

`ifdef WPTR_ALMOST_FULL_EN
   localparam logic [ASIZE:0] AF_LIMIT = PW'(AF_THRESH);

   logic [ASIZE:0] rbin;
   logic [ASIZE:0] wcount_next;

   assign rbin        = PW'(gray2bin(PTR_MAX_W'(wq2_rptr)));
   assign wcount_next = wbinnext - rbin;

   always_ff @(posedge wclk) begin
      if (wrst) begin
         wcount       <= '0;
         walmost_full <= 1'b0;
      end else begin
         wcount       <= wcount_next;
         walmost_full <= (wcount_next >= AF_LIMIT);
      end
   end
`else
   assign wcount       = '0;
   assign walmost_full = 1'b0;
`endif

endmodule : wptr_full
`default_nettype wire

// File: tb/tb_wptr_full.sv
`default_nettype none
// ============================================================================
// Module      : tb_wptr_full
// Description : Self-checking bench for wptr_full against an occupancy model
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wptr_full;

   localparam int ASIZE     = 4;
   localparam int AF_THRESH = 14;
   localparam int DEPTH     = 1 << ASIZE;
`ifdef WPTR_ALMOST_FULL_EN
   localparam bit AFE = 1'b1;
`else
   localparam bit AFE = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic             w_en;
   logic [ASIZE:0]   rd_bin;
   logic [ASIZE:0]   rptr;
   logic [ASIZE-1:0] waddr;
   logic [ASIZE:0]   wptr;
   logic             wfull;
   logic             walmost_full;
   logic [ASIZE:0]   wcount;
   logic             woverflow;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // The read side presents its binary read count as a Gray pointer.
   assign rptr = rd_bin ^ (rd_bin >> 1);

   wptr_full #(.ASIZE(ASIZE), .AF_THRESH(AF_THRESH)) dut (
      .wclk         (clk),
      .wrst         (rst),
      .w_en         (w_en),
      .rptr         (rptr),
      .waddr        (waddr),
      .wptr         (wptr),
      .wfull        (wfull),
      .walmost_full (walmost_full),
      .wcount       (wcount),
      .woverflow    (woverflow)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: writes counted in binary, read count seen two edges late.
   logic [ASIZE:0] m_wbin, s1, s2, occ, nb;
   logic           m_full, m_ovf, m_af, m_valid = 1'b0;
   logic [ASIZE:0] m_cnt;

   always @(posedge clk) begin
      if (rst) begin
         m_wbin = '0; s1 = '0; s2 = '0; m_full = 1'b0; m_ovf = 1'b0;
         m_cnt = '0; m_af = 1'b0; m_valid = 1'b1;
      end else begin
         m_ovf  = m_ovf | (w_en & m_full);
         nb     = m_wbin + ((w_en && !m_full) ? 1 : 0);
         occ    = nb - s2;
         m_full = (occ == DEPTH);
         m_cnt  = occ;
         m_af   = (int'(occ) >= AF_THRESH);
         s2     = s1;
         s1     = rd_bin;
         m_wbin = nb;
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         chk("waddr", 32'(waddr), 32'(m_wbin[ASIZE-1:0]));
         chk("wptr", 32'(wptr), 32'(m_wbin ^ (m_wbin >> 1)));
         chk("wfull", 32'(wfull), 32'(m_full));
         chk("woverflow", 32'(woverflow), 32'(m_ovf));
         chk("wcount", 32'(wcount), AFE ? 32'(m_cnt) : 32'd0);
         chk("walmost_full", 32'(walmost_full), AFE ? 32'(m_af) : 32'd0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int wprob, rprob;
      rst = 1'b1; w_en = 1'b1; rd_bin = '0;
      tick(); tick();
      chk("rst_waddr", 32'(waddr), 0);
      chk("rst_wptr", 32'(wptr), 0);
      chk("rst_wfull", 32'(wfull), 0);
      chk("rst_wovf", 32'(woverflow), 0);
      chk("rst_wcount", 32'(wcount), 0);

      // Fill from empty.
      rst = 1'b0; w_en = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         tick();
         if (i == 13) chk("af_13", 32'(walmost_full), 0);
         if (i == 14) begin
            chk("af_14", 32'(walmost_full), AFE ? 1 : 0);
            chk("cnt_14", 32'(wcount), AFE ? 14 : 0);
         end
         if (i == 15) chk("full_15", 32'(wfull), 0);
      end
      chk("full_16", 32'(wfull), 1);
      chk("wptr_16", 32'(wptr), 32'h18);
      chk("waddr_16", 32'(waddr), 0);
      chk("ovf_16", 32'(woverflow), 0);

      // Write attempt while full.
      tick();
      chk("ovf_wptr", 32'(wptr), 32'h18);
      chk("ovf_set", 32'(woverflow), 1);
      w_en = 1'b0;
      tick();
      chk("ovf_sticky", 32'(woverflow), 1);

      // Read one entry; full drops on the third edge.
      rd_bin = 5'd1;
      tick(); chk("drain_1", 32'(wfull), 1);
      tick(); chk("drain_2", 32'(wfull), 1);
      tick(); chk("drain_3", 32'(wfull), 0);
      chk("drain_cnt", 32'(wcount), AFE ? 15 : 0);

      // Wrap: reads follow writes closely.
      rst = 1'b1; tick(); rst = 1'b0; rd_bin = '0;
      w_en = 1'b1;
      for (int i = 1; i <= 32; i++) begin
         tick();
         chk("wrap_waddr", 32'(waddr), 32'(i % 16));
         chk("wrap_full", 32'(wfull), 0);
         rd_bin = 5'(i);
      end
      chk("wrap_wptr", 32'(wptr), 0);

      // Reset in the middle of operation.
      rst = 1'b1; rd_bin = '0; tick(); rst = 1'b0;
      repeat (7) tick();
      chk("mid_waddr7", 32'(waddr), 7);
      rst = 1'b1; tick();
      chk("mid_waddr", 32'(waddr), 0);
      chk("mid_wptr", 32'(wptr), 0);
      chk("mid_wfull", 32'(wfull), 0);
      chk("mid_wcount", 32'(wcount), 0);
      chk("mid_af", 32'(walmost_full), 0);
      chk("mid_ovf", 32'(woverflow), 0);
      rst = 1'b0;
      tick();
      chk("post_waddr", 32'(waddr), 1);
      chk("post_wptr", 32'(wptr), 1);

      // Randomized traffic with phases of filling and draining.
      wprob = 90; rprob = 20;
      for (int c = 0; c < 3000; c++) begin
         if (c % 200 == 0) begin
            case ($urandom_range(0, 2))
               0: begin wprob = 90; rprob = 20; end
               1: begin wprob = 50; rprob = 50; end
               default: begin wprob = 10; rprob = 80; end
            endcase
         end
         w_en = ($urandom_range(0, 99) < wprob);
         if ($urandom_range(0, 499) == 0) begin
            rst = 1'b1; rd_bin = '0;
         end else begin
            rst = 1'b0;
            if ((rd_bin != m_wbin) && ($urandom_range(0, 99) < rprob))
               rd_bin = rd_bin + 1'b1;
         end
         tick();
      end
      rst = 1'b0; w_en = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_wptr_full
`default_nettype wire

// File: doc/wptr_full.md
WPTR_FULL -- requirements
Module: wptr_full

Interface
REQ-001 SHALL have parameter ASIZE, default 4, FIFO address width; depth 2^ASIZE; legal range 2..16.
REQ-002 SHALL have parameter AF_THRESH, default (1<<ASIZE)-2, the occupancy at which walmost_full asserts.
REQ-003 SHALL have one clock and a synchronous, active-high reset.
REQ-004 wclk  input  1  write-domain clock; all state on posedge.
REQ-005 wrst  input  1  synchronous active-high reset.
REQ-006 w_en  input  1  write request from producer.
REQ-007 rptr  input  ASIZE+1  Gray-coded read pointer from read domain (asynchronous).
REQ-008 waddr  output  ASIZE  binary write address to the FIFO memory.
REQ-009 wptr  output  ASIZE+1  Gray-coded write pointer to read domain, registered.
REQ-010 wfull  output  1  FIFO full, registered; also drives the memory write gate.
REQ-011 walmost_full  output  1  occupancy >= AF_THRESH, registered.
REQ-012 wcount  output  ASIZE+1  write-side occupancy estimate, registered.
REQ-013 woverflow  output  1  sticky: a write was attempted while full.

Function
REQ-014 SHALL accept a write when w_en && !wfull at a wclk edge; wbin increments by 1 and waddr/wptr update on that same edge.
REQ-015 SHALL hold wbin (ASIZE+1 bits) and wptr = wbin ^ (wbin>>1); waddr = wbin[ASIZE-1:0]; wrap from 2^(ASIZE+1)-1 to 0 is modulo, no special case.
REQ-016 SHALL synchronize rptr through a two-flop chain (wq1_rptr, wq2_rptr); only wq2_rptr feeds logic.
REQ-017 SHALL register wfull = (wgraynext == {~wq2_rptr[ASIZE:ASIZE-1], wq2_rptr[ASIZE-2:0]}), where wgraynext is the Gray code of the next wbin value.
REQ-018 SHALL assert wfull on the same edge as the write that fills the FIFO; zero-cycle lag.
REQ-019 SHALL deassert wfull on the third wclk edge after rptr changes: two sync flops plus the wfull register.
REQ-020 SHALL, when w_en && wfull, drop the write, leave wbin/wptr unchanged, and set woverflow on the next edge; woverflow clears only on reset.
REQ-021 SHALL compute wcount = wbinnext - gray2bin(wq2_rptr) modulo 2^(ASIZE+1), registered; range 0..2^ASIZE.
REQ-022 SHALL register walmost_full = (next wcount >= AF_THRESH).
REQ-023 SHALL treat a read pointer change and a write on the same edge independently; pessimistic full (late deassert) is correct, never late assert.

Reset
REQ-024 SHALL on wrst clear wbin, wptr, waddr, wq1_rptr, wq2_rptr, wcount, wfull, walmost_full and woverflow to 0 at the next edge; reset overrides w_en.
REQ-025 SHALL, on reset mid-operation, abandon pointer state; the read domain is reset by the system in the same window.

Configuration
REQ-026 SHALL compile walmost_full and wcount logic only when WPTR_ALMOST_FULL_EN is defined.
REQ-027 SHALL, without WPTR_ALMOST_FULL_EN, keep both ports but tie them to constant 0, with no gray2bin or subtractor.

Structure
REQ-028 SHALL take shared Gray helpers (bin2gray, gray2bin functions) and default ASIZE constant from package fifo_pkg, also used by the read-pointer block.
REQ-029 SHALL instantiate one sub-module, sync_r2w (parameterized two-flop synchronizer with wclk/wrst), for REQ-016.

Verification (ASIZE=4, AF_THRESH=14)
REQ-030 Reset: wrst=1 for 2 edges with w_en=1 -> waddr=0, wptr=0, wfull=0, woverflow=0, wcount=0.
REQ-031 Fill: rptr=0, 16 consecutive w_en pulses -> wfull=1 on 16th edge, wptr=5'b11000, waddr=0; walmost_full=1 from 14th edge, wcount=14 there.
REQ-032 Overflow: while full, w_en=1 one cycle -> wptr stays 5'b11000, woverflow=1 next edge, still 1 after w_en=0.
REQ-033 Drain: while full, rptr=5'b00001 -> wfull=0 exactly on third edge, wcount=15 same edge.
REQ-034 Wrap: 32 writes with rptr tracking wptr after sync delay -> wfull never asserts, wptr returns to 0, waddr cycles 0..15 twice.
REQ-035 Mid-op reset: after 7 writes assert wrst one edge -> all outputs 0 next edge; next write gives waddr=1, wptr=5'b00001.
